// File: rtl/btb_predictor_pkg.sv
// btb_predictor_pkg: shared branch-class encodings, counter constants and counter helper
package btb_predictor_pkg;

    typedef enum logic [1:0] {
        BTB_BRANCH = 2'd0,
        BTB_JUMP   = 2'd1,
        BTB_CALL   = 2'd2,
        BTB_RET    = 2'd3
    } btb_type_e;

    localparam logic [1:0] BTB_CTR_WEAK_T   = 2'd2;
    localparam logic [1:0] BTB_CTR_STRONG_T = 2'd3;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        return taken ? ((ctr == 2'd3) ? ctr : ctr + 2'd1) : ((ctr == 2'd0) ? ctr : ctr - 2'd1);
    endfunction

endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack that overwrites its oldest entry when full
module ras_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty
);

    localparam int           PW    = $clog2(RAS_DEPTH);
    localparam logic [PW:0]  FULL  = (PW+1)'(RAS_DEPTH);
    localparam logic [PW:0]  ONE_C = (PW+1)'(1);
    localparam logic [PW-1:0] ONE_P = PW'(1);

    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   ptr;
    logic [PW:0]     count;

    assign empty = (count == '0);
    assign top   = mem[ptr - ONE_P];

    // ptr is the next free slot; a push when full lands on the oldest entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr   <= ptr + ONE_P;
            count <= (count == FULL) ? count : count + ONE_C;
        end else if (pop && !empty) begin
            ptr   <= ptr - ONE_P;
            count <= count - ONE_C;
        end
    end

    // return addresses need no reset: count gates their visibility
    always_ff @(posedge clk) begin
        if (push) mem[ptr] <= push_data;
    end

endmodule

// File: rtl/btb_predictor.sv
// btb_predictor: direct-mapped BTB with 2-bit direction counters and a return-address stack
module btb_predictor
    import btb_predictor_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ENTRIES   = 64,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            lookup_valid,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken,
    input  logic [1:0]      upd_type
);

    localparam int IDX = $clog2(ENTRIES);
    localparam int TAG = XLEN - IDX - 2;

    logic [ENTRIES-1:0] valid;
    logic [1:0]         ctr     [ENTRIES];
    logic [TAG-1:0]     tags    [ENTRIES];
    logic [XLEN-1:0]    targets [ENTRIES];
    btb_type_e          types   [ENTRIES];

    logic [IDX-1:0]  lidx, uidx;
    logic [TAG-1:0]  ltag, utag;
    btb_type_e       ltype, utype;
    logic            upd_hit, wr_data, ras_push, ras_pop, ras_empty;
    logic [XLEN-1:0] ras_top, fall_through;
    logic            unused_bits;

    assign lidx  = lookup_pc[IDX+1:2];
    assign ltag  = lookup_pc[XLEN-1:IDX+2];
    assign uidx  = upd_pc[IDX+1:2];
    assign utag  = upd_pc[XLEN-1:IDX+2];
    assign ltype = types[lidx];
    assign utype = btb_type_e'(upd_type);
    assign unused_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign pred_hit     = valid[lidx] && (tags[lidx] == ltag);
    assign pred_taken   = pred_hit && ((ltype != BTB_BRANCH) || ctr[lidx][1]);
    assign fall_through = lookup_pc + XLEN'(4);
    assign pred_target  = !pred_taken ? fall_through :
                          (ltype == BTB_RET && !ras_empty) ? ras_top : targets[lidx];

    assign ras_push = lookup_valid && pred_hit && (ltype == BTB_CALL);
    assign ras_pop  = lookup_valid && pred_hit && (ltype == BTB_RET);

    assign upd_hit = valid[uidx] && (tags[uidx] == utag);
    assign wr_data = upd_valid && (upd_taken || (upd_hit && utype != BTB_BRANCH));

    // valid bits and direction counters: cleared on reset, trained from execute
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= '0;
        end else if (upd_valid) begin
            if (upd_hit)
                ctr[uidx] <= (utype == BTB_BRANCH) ? ctr_next(ctr[uidx], upd_taken) : BTB_CTR_STRONG_T;
            else if (upd_taken) begin
                valid[uidx] <= 1'b1;
                ctr[uidx]   <= (utype == BTB_BRANCH) ? BTB_CTR_WEAK_T : BTB_CTR_STRONG_T;
            end
        end
    end

    // tag/target/type payload: written on allocation, taken branches and any jump update
    always_ff @(posedge clk) begin
        if (wr_data) begin
            tags[uidx]    <= utag;
            targets[uidx] <= upd_target;
            types[uidx]   <= utype;
        end
    end

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (fall_through),
        .top       (ras_top),
        .empty     (ras_empty)
    );

endmodule

// File: tb/tb_btb_predictor.sv
// tb_btb_predictor: directed scoreboard bench for the BTB/RAS predictor
module tb_btb_predictor;
    import btb_predictor_pkg::*;

    localparam int XLEN      = 32;
    localparam int ENTRIES   = 64;
    localparam int RAS_DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            lookup_valid = 1'b0;
    logic [XLEN-1:0] lookup_pc = '0;
    logic            pred_hit, pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            upd_valid = 1'b0;
    logic [XLEN-1:0] upd_pc = '0;
    logic [XLEN-1:0] upd_target = '0;
    logic            upd_taken = 1'b0;
    logic [1:0]      upd_type = 2'd0;

    typedef struct {
        string           tag;
        logic            hit;
        logic            taken;
        logic [XLEN-1:0] tgt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    btb_predictor #(
        .XLEN      (XLEN),
        .ENTRIES   (ENTRIES),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lookup_valid (lookup_valid),
        .lookup_pc    (lookup_pc),
        .pred_hit     (pred_hit),
        .pred_taken   (pred_taken),
        .pred_target  (pred_target),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_target   (upd_target),
        .upd_taken    (upd_taken),
        .upd_type     (upd_type)
    );

    task automatic compare();
        exp_t e = sb.pop_front();
        checks++;
        assert (pred_hit === e.hit) else begin
            errors++;
            $error("FAIL %s hit: got %0b want %0b", e.tag, pred_hit, e.hit);
        end
        checks++;
        assert (pred_taken === e.taken) else begin
            errors++;
            $error("FAIL %s taken: got %0b want %0b", e.tag, pred_taken, e.taken);
        end
        checks++;
        assert (pred_target === e.tgt) else begin
            errors++;
            $error("FAIL %s target: got %h want %h", e.tag, pred_target, e.tgt);
        end
    endtask

    task automatic set_upd(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt,
                           input logic tk, input btb_type_e t);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_target = tgt;
        upd_taken  = tk;
        upd_type   = t;
    endtask

    task automatic upd(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt,
                       input logic tk, input btb_type_e t);
        set_upd(pc, tgt, tk, t);
        lookup_valid = 1'b0;
        @(negedge clk);
        upd_valid = 1'b0;
    endtask

    task automatic look(input string tag, input logic lv, input logic [XLEN-1:0] pc,
                        input logic eh, input logic et, input logic [XLEN-1:0] etgt);
        exp_t e;
        lookup_valid = lv;
        lookup_pc    = pc;
        e.tag = tag;
        e.hit = eh;
        e.taken = et;
        e.tgt = etgt;
        sb.push_back(e);
        #1 compare();
        @(negedge clk);
        upd_valid    = 1'b0;
        lookup_valid = 1'b0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        look("rst_low", 1'b1, 32'h100, 1'b0, 1'b0, 32'h104);
        rst_n = 1'b1;
        look("rst_high", 1'b1, 32'h100, 1'b0, 1'b0, 32'h104);

        upd(32'h200, 32'h180, 1'b1, BTB_BRANCH);
        look("br_alloc", 1'b0, 32'h200, 1'b1, 1'b1, 32'h180);
        upd(32'h200, 32'h180, 1'b0, BTB_BRANCH);
        look("br_ctr1", 1'b0, 32'h200, 1'b1, 1'b0, 32'h204);
        upd(32'h200, 32'h180, 1'b0, BTB_BRANCH);
        look("br_ctr0", 1'b0, 32'h200, 1'b1, 1'b0, 32'h204);
        upd(32'h200, 32'h180, 1'b0, BTB_BRANCH);
        upd(32'h200, 32'h180, 1'b1, BTB_BRANCH);
        look("br_floor", 1'b0, 32'h200, 1'b1, 1'b0, 32'h204);
        upd(32'h200, 32'h180, 1'b1, BTB_BRANCH);
        look("br_up2", 1'b0, 32'h200, 1'b1, 1'b1, 32'h180);
        upd(32'h200, 32'h180, 1'b1, BTB_BRANCH);
        upd(32'h200, 32'h180, 1'b1, BTB_BRANCH);
        upd(32'h200, 32'h180, 1'b0, BTB_BRANCH);
        look("br_ceil", 1'b0, 32'h200, 1'b1, 1'b1, 32'h180);
        upd(32'h200, 32'h180, 1'b0, BTB_BRANCH);
        look("br_down1", 1'b0, 32'h200, 1'b1, 1'b0, 32'h204);

        upd(32'h200, 32'h180, 1'b1, BTB_BRANCH);
        upd(32'h200 + 4 * ENTRIES, 32'h900, 1'b1, BTB_JUMP);
        look("alias_evict", 1'b0, 32'h200, 1'b0, 1'b0, 32'h204);
        look("alias_jump", 1'b0, 32'h300, 1'b1, 1'b1, 32'h900);
        upd(32'h200 + 8 * ENTRIES, 32'h700, 1'b0, BTB_BRANCH);
        look("alias_keep", 1'b0, 32'h300, 1'b1, 1'b1, 32'h900);
        look("alias_nt_miss", 1'b0, 32'h400, 1'b0, 1'b0, 32'h404);

        upd(32'h300, 32'h800, 1'b1, BTB_CALL);
        upd(32'h810, 32'h0, 1'b1, BTB_RET);
        look("call_fetch", 1'b1, 32'h300, 1'b1, 1'b1, 32'h800);
        look("ret_ras", 1'b1, 32'h810, 1'b1, 1'b1, 32'h304);
        look("ret_empty", 1'b1, 32'h810, 1'b1, 1'b1, 32'h0);

        for (int i = 0; i < RAS_DEPTH + 1; i++)
            upd(32'h1000 + 32'(i * 16), 32'h2000, 1'b1, BTB_CALL);
        upd(32'h2044, 32'h0, 1'b1, BTB_RET);
        for (int i = 0; i < RAS_DEPTH + 1; i++)
            look("ovf_call", 1'b1, 32'h1000 + 32'(i * 16), 1'b1, 1'b1, 32'h2000);
        for (int i = 0; i < RAS_DEPTH; i++)
            look("ovf_pop", 1'b1, 32'h2044, 1'b1, 1'b1, 32'h1044 - 32'(i * 16));
        look("ovf_empty", 1'b1, 32'h2044, 1'b1, 1'b1, 32'h0);
        look("nolv_call", 1'b0, 32'h1000, 1'b1, 1'b1, 32'h2000);
        look("nolv_ret", 1'b1, 32'h2044, 1'b1, 1'b1, 32'h0);

        set_upd(32'h200, 32'h180, 1'b1, BTB_BRANCH);
        look("same_old", 1'b0, 32'h200, 1'b0, 1'b0, 32'h204);
        look("same_new", 1'b0, 32'h200, 1'b1, 1'b1, 32'h180);

        rst_n = 1'b0;
        look("mid_rst_br", 1'b0, 32'h200, 1'b0, 1'b0, 32'h204);
        look("mid_rst_call", 1'b1, 32'h1000, 1'b0, 1'b0, 32'h1004);
        rst_n = 1'b1;
        look("post_rst_ret", 1'b1, 32'h2044, 1'b0, 1'b0, 32'h2048);
        look("post_rst_jump", 1'b0, 32'h300, 1'b0, 1'b0, 32'h304);
        look("pc_wrap", 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Parametrised fetch-stage branch predictor: direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters and a return-address stack (RAS).
- Looked up combinationally with the fetch PC; drives predicted_taken/target into fetch.
- Trained one cycle-per-update from the execute-stage branch resolution outputs (update strobe, resolved PC, target, taken, instruction class).

Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 64, BTB entry count; power of two, ≥2. IDX = log2(ENTRIES), TAG = XLEN-IDX-2.
- RAS_DEPTH, 4, return stack depth; power of two, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- lookup_valid  in  1  fetch advances this cycle (gates RAS push/pop only).
- lookup_pc  in  XLEN  fetch PC.
- pred_hit  out  1  valid entry with matching tag at lookup_pc.
- pred_taken  out  1  predict redirect.
- pred_target  out  XLEN  predicted next PC.
- upd_valid  in  1  resolved branch/jump in execute.
- upd_pc  in  XLEN  PC of resolved instruction.
- upd_target  in  XLEN  resolved jump address (JALR already LSB-cleared).
- upd_taken  in  1  resolved taken (always 1 for jumps).
- upd_type  in  2  BTB_BRANCH=0, BTB_JUMP=1, BTB_CALL=2, BTB_RET=3.

Behaviour:
- Entry fields: valid, tag, target, ctr[1:0], type[1:0]. index = pc[IDX+1:2], tag = pc[XLEN-1:IDX+2].
- Lookup is purely combinational, 0-cycle latency; reads array state as of the last clock edge, with no bypass of a same-cycle update.
- pred_hit = valid & tag match.
- pred_taken = hit & (type==BRANCH ? ctr[1] : 1).
- pred_target:
  - not pred_taken → lookup_pc+4 (modulo 2^XLEN).
  - RET and RAS non-empty → RAS top.
  - otherwise → stored target.
- RAS is updated speculatively at fetch, only when lookup_valid & pred_hit:
  - CALL: push lookup_pc+4.
  - RET: pop.
- RAS is a circular buffer with pointer and count (0..RAS_DEPTH):
  - Push when full: overwrite oldest, pointer wraps, count stays RAS_DEPTH.
  - Pop when empty: no-op, count stays 0; the prediction falls back to the BTB target.
  - No repair on misprediction; the RAS holds its contents through pipeline flushes.
- Update, registered on the clk edge when upd_valid:
  - Hit at upd_pc, BRANCH: ctr saturating +1 if taken else -1 (3 stays 3, 0 stays 0); target and type rewritten if taken.
  - Hit at upd_pc, non-BRANCH: target and type rewritten, ctr set to 3.
  - Miss (invalid or tag differs), allocate only if upd_taken. Overwrite the slot with valid=1, new tag, target, type; ctr=2 (weakly taken) for BRANCH, 3 otherwise.
  - Miss with not-taken branch: no write; any existing entry at that index is kept.
- Simultaneous lookup and update at the same index: lookup returns the pre-update entry; the new value is visible the next cycle.
- Simultaneous RAS push/pop is impossible (one lookup per cycle). Execute-side updates never touch the RAS.
- Reset (async assert, sync-safe deassert by the system):
  - all valid=0, ctr=0, RAS count=0, pointer=0.
  - Outputs during and after reset: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4.
  - Reset mid-operation discards all training.
- Target/tag storage may be flops or distributed RAM; valid bits must be flops so they clear on reset.

Decomposition:
- Shared defines file gains BTB_BRANCH/JUMP/CALL/RET encodings and the reset counter values (BTB_CTR_WEAK_T=2, BTB_CTR_STRONG_T=3).
- Execute stage derives upd_type from opcode/rd/rs1:
  - JAL/JALR with rd∈{x1,x5} → CALL.
  - JALR with rd=x0, rs1∈{x1,x5} → RET.
- One sub-module: ras_stack (params XLEN, RAS_DEPTH; ports clk, rst_n, push, pop, push_data, top, empty).

Test Plan:
- Reset then lookup_pc=0x100 → pred_hit=0, pred_taken=0, pred_target=0x104; release reset, same result.
- Branch training:
  - upd BRANCH pc=0x200, target=0x180, taken=1 → next-cycle lookup 0x200 gives hit=1, taken=1, target=0x180 (ctr=2).
  - Two not-taken updates → taken=0, target=0x204 (ctr=0).
  - Third not-taken update → ctr stays 0.
- Alias: train 0x200 (taken), then upd JUMP pc=0x200+4*ENTRIES → lookup 0x200 misses. Not-taken BRANCH at a third alias does not evict.
- Call/return:
  - Train CALL at 0x300 (target 0x800) and RET at 0x810 (target 0x0).
  - Fetch 0x300 → push 0x304; fetch 0x810 → pred_target=0x304.
  - Fetch 0x810 again with RAS empty → target 0x0.
- RAS overflow: RAS_DEPTH+1 calls from 0x1000,0x1010,… → pops return the newest RAS_DEPTH addresses in LIFO order, then fall back to the BTB target.
- Same-cycle lookup and update at 0x200 → old prediction that cycle, new the next; assert rst_n mid-sequence → all predictions revert to pc+4.
